// File: rtl/zzzz_zzzx_comparator_if.sv
// zzzz_zzzx_comparator_if: word/dictionary inputs and registered classification results
interface zzzz_zzzx_comparator_if #(
    parameter int WIDTH = 32,
    parameter int WORDS = 16,
    parameter int BYTE  = 8
);
    localparam int NB = WORDS * WIDTH / BYTE;
    localparam int IW = $clog2(NB);
    logic [WIDTH-1:0]       in_word;
    logic [WORDS*WIDTH-1:0] dictionary_i;
    logic [IW-1:0]          dictionary_index;
    logic [BYTE-1:0]        matched_byte;
    logic [BYTE+3:0]        out_code;
    logic                   zzzz_hit;
    logic                   zzzx_hit;
    logic                   dict_hit;
    modport master (
        output in_word, dictionary_i,
        input  dictionary_index, matched_byte, out_code, zzzz_hit, zzzx_hit, dict_hit
    );
    modport slave (
        input  in_word, dictionary_i,
        output dictionary_index, matched_byte, out_code, zzzz_hit, zzzx_hit, dict_hit
    );
endinterface

// File: rtl/zzzz_zzzx_comparator.sv
// zzzz_zzzx_comparator: classifies words as zzzz/zzzx/neither and looks up zzzx low bytes in the dictionary
module zzzz_zzzx_comparator #(
    parameter int WIDTH = 32,
    parameter int WORDS = 16,
    parameter int BYTE  = 8
) (
    input logic clk,
    input logic reset,
    zzzz_zzzx_comparator_if.slave bus
);
    localparam int NB = WORDS * WIDTH / BYTE;
    localparam int IW = $clog2(NB);
    logic [BYTE-1:0] low;
    logic            is_zzzz;
    logic            is_zzzx;
    logic            found;
    logic [IW-1:0]   idx;
    assign low     = bus.in_word[BYTE-1:0];
    assign is_zzzz = bus.in_word == '0;
    assign is_zzzx = bus.in_word[WIDTH-1:BYTE] == '0 && low != '0;
    // scan from the top so the lowest matching index is the last one written
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NB - 1; k >= 0; k--)
            if (bus.dictionary_i[k*BYTE +: BYTE] == low) begin
                found = 1'b1;
                idx   = IW'(k);
            end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.zzzz_hit         <= 1'b0;
            bus.zzzx_hit         <= 1'b0;
            bus.dict_hit         <= 1'b0;
            bus.dictionary_index <= '0;
            bus.matched_byte     <= '0;
            bus.out_code         <= '0;
        end else begin
            bus.zzzz_hit         <= is_zzzz;
            bus.zzzx_hit         <= is_zzzx;
            bus.dict_hit         <= is_zzzx && found;
            bus.dictionary_index <= (is_zzzx && found) ? idx : '0;
            bus.matched_byte     <= (is_zzzx && found) ? low : '0;
            bus.out_code         <= is_zzzx ? {4'b1101, low} : '0;
        end
    end
endmodule

// File: tb/tb_zzzz_zzzx_comparator.sv
// tb_zzzz_zzzx_comparator: scoreboard bench for the zzzz/zzzx classifier and dictionary lookup
module tb_zzzz_zzzx_comparator;
    typedef struct packed {
        logic [5:0]  idx;
        logic [7:0]  mb;
        logic [11:0] code;
        logic        zz;
        logic        zx;
        logic        dh;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [511:0] dict;
    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    zzzz_zzzx_comparator_if bus ();
    zzzz_zzzx_comparator dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic exp_t model(input logic [31:0] w, input logic [511:0] d, input logic r);
        exp_t e = '0;
        int k = 0;
        if (r) return e;
        if (w == 32'd0) begin
            e.zz = 1'b1;
            return e;
        end
        if (w[31:8] != 24'd0) return e;
        e.zx = 1'b1;
        e.code = {4'hD, w[7:0]};
        while (k < 64 && d[8*k +: 8] != w[7:0]) k++;
        if (k < 64) begin
            e.dh = 1'b1;
            e.idx = 6'(k);
            e.mb = d[8*k +: 8];
        end
        return e;
    endfunction
    task automatic step(input logic [31:0] w, input logic r);
        exp_t e;
        bus.in_word = w;
        bus.dictionary_i = dict;
        reset = r;
        sb.push_back(model(w, dict, r));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("zzzz_hit", 32'(bus.zzzz_hit), 32'(e.zz));
        check("zzzx_hit", 32'(bus.zzzx_hit), 32'(e.zx));
        check("dict_hit", 32'(bus.dict_hit), 32'(e.dh));
        check("dictionary_index", 32'(bus.dictionary_index), 32'(e.idx));
        check("matched_byte", 32'(bus.matched_byte), 32'(e.mb));
        check("out_code", 32'(bus.out_code), 32'(e.code));
    endtask
    initial begin
        for (int k = 0; k < 64; k++) dict[8*k +: 8] = 8'(k);
        bus.in_word = 32'hFFFF_FFFF;
        bus.dictionary_i = dict;
        step(32'h0000_0005, 1'b1);
        step(32'h0000_0005, 1'b1);
        check("reset_out_code", 32'(bus.out_code), 32'h0);
        step(32'h0000_0000, 1'b0);
        check("zzzz_code", 32'(bus.out_code), 32'h000);
        step(32'h0000_000A, 1'b0);
        check("zzzx_A_code", 32'(bus.out_code), 32'hD0A);
        check("zzzx_A_idx", 32'(bus.dictionary_index), 32'd10);
        step(32'hFF00_000A, 1'b0);
        step(32'h0000_002D, 1'b0);
        check("zzzx_2D_idx", 32'(bus.dictionary_index), 32'd45);
        step(32'h0000_003F, 1'b0);
        step(32'h0000_0100, 1'b0);
        dict[8*7 +: 8] = 8'hAB;
        dict[8*30 +: 8] = 8'hAB;
        step(32'h0000_00AB, 1'b0);
        check("prio_idx", 32'(bus.dictionary_index), 32'd7);
        check("prio_byte", 32'(bus.matched_byte), 32'hAB);
        step(32'h0000_00C8, 1'b0);
        check("nomatch_hit", 32'(bus.dict_hit), 32'd0);
        check("nomatch_code", 32'(bus.out_code), 32'hDC8);
        step(32'h0000_0007, 1'b0);
        step(32'h0000_001E, 1'b0);
        step(32'h0000_0011, 1'b1);
        step(32'h0000_0011, 1'b0);
        check("post_reset_idx", 32'(bus.dictionary_index), 32'd17);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] w;
            for (int k = 0; k < 64; k++) dict[8*k +: 8] = 8'($urandom_range(0, 40));
            case ($urandom_range(0, 3))
                0: w = 32'd0;
                1: w = $urandom;
                default: w = 32'($urandom_range(1, 48));
            endcase
            step(w, ($urandom_range(0, 15) == 0));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
